// File: rtl/prio_arb_enc.sv
// prio_arb_enc: registered N-channel priority arbiter/encoder with a sticky grant
// and a count of accepted grants. The index is latched one edge after req; every
// output comes from a flop.
// Backpressure: a grant is held until gnt_ack. Acceptance can re-arbitrate on the
// same edge, so one grant per cycle is possible.
// Ports: clk/rst (async, active-high), req[N], mode (0 fixed, 1 round-robin),
//        gnt_ack; out: gnt_valid, gnt_idx[IDX_W], gnt_onehot[N], gnt_cnt[CNT_W].
// Build option: define PRIO_ARB_RR_EN to add the round-robin pointer and honour
//        mode. Without it, arbitration is fixed priority (highest index wins).
module prio_arb_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             gnt_ack,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic [CNT_W-1:0] gnt_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_req;
  logic             accept;
  logic             arb_en;
  logic [IDX_W-1:0] win_idx;

  // Index of the highest set bit (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] highest(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign any_req = |req;
  assign accept  = (state_q == S_GRANT) && gnt_ack;
  // A new index may be chosen from IDLE, or on the accept edge (no bubble).
  assign arb_en  = (state_q == S_IDLE) || accept;

`ifdef PRIO_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     low_mask;
  logic [N-1:0]     masked_req;

  // The pointer takes the accepted index on the same edge that re-arbitrates,
  // so the search below uses the updated pointer.
  assign ptr_d = accept ? idx_q : ptr_q;

  // Search order p-1 .. 0, then N-1 .. p: pick the highest request below p
  // first; if none exist, every request is >= p and the plain highest wins.
  always_comb begin
    low_mask = '0;
    for (int i = 0; i < N; i++) begin
      low_mask[i] = (i < int'(ptr_d));
    end
  end

  assign masked_req = req & low_mask;

  always_comb begin
    if (mode && (|masked_req)) win_idx = highest(masked_req);
    else                       win_idx = highest(req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed-priority build: mode has no effect.
  logic unused_mode;
  assign unused_mode = mode;
  assign win_idx     = highest(req);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_GRANT;
      S_GRANT: if (gnt_ack && !any_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-state: grant is frozen unless arbitrating; one-hot clears when
  // the FSM falls back to IDLE while the index keeps its last value.
  always_comb begin
    idx_d    = idx_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    if (accept) cnt_d = cnt_q + CNT_W'(1);
    if (arb_en) begin
      onehot_d = '0;
      if (any_req) begin
        idx_d             = win_idx;
        onehot_d[win_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt_valid  = (state_q == S_GRANT);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign gnt_cnt    = cnt_q;

endmodule

// File: tb/tb_prio_arb_enc.sv
// tb_prio_arb_enc: randomized and directed stimulus for prio_arb_enc (N=8,
// CNT_W=8). A reference model predicts each edge; a monitor compares on the
// falling edge. Honours PRIO_ARB_RR_EN the same way as the design.
module tb_prio_arb_enc;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic       gnt_ack;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic [7:0] gnt_cnt;

`ifdef PRIO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  prio_arb_enc #(.N(8), .IDX_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .gnt_ack   (gnt_ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_onehot(gnt_onehot),
    .gnt_cnt   (gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state
  bit m_valid;
  int m_idx;
  int m_cnt;
  int m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner from the written priority rules, walking the search order directly.
  function automatic int pick(input logic [7:0] r, input bit rr, input int p);
    if (rr) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (p - k + 8) % 8;
        if (r[c]) return c;
      end
    end else begin
      for (int i = 7; i >= 0; i--) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_cnt   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic m, input logic a);
    exp_t e;
    bit   acc;
    acc = m_valid && a;
    if (acc) begin
      m_cnt = (m_cnt + 1) % 256;
      m_ptr = m_idx;
    end
    if (!m_valid || acc) begin
      if (r != 8'h00) begin
        m_valid = 1'b1;
        m_idx   = pick(r, RR && m, m_ptr);
      end else begin
        m_valid = 1'b0;
      end
    end
    e.v   = m_valid;
    e.idx = 3'(m_idx);
    e.oh  = m_valid ? 8'(1 << m_idx) : 8'h00;
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Apply inputs, let one edge happen, record the prediction.
  task automatic step(input logic [7:0] r, input logic m, input logic a);
    req     = r;
    mode    = m;
    gnt_ack = a;
    @(posedge clk);
    model_edge(r, m, a);
    #1;
  endtask

  // Raise reset between edges and check outputs clear with no clock edge.
  task automatic do_reset(input logic [7:0] r_hold);
    @(negedge clk);
    #1;
    req = r_hold;
    rst = 1'b1;
    #1;
    chk("rst_valid", gnt_valid, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_onehot", gnt_onehot, 0);
    chk("rst_cnt", gnt_cnt, 0);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_valid", gnt_valid, e.v);
      chk("sb_idx", gnt_idx, e.idx);
      chk("sb_onehot", gnt_onehot, e.oh);
      chk("sb_cnt", gnt_cnt, e.cnt);
    end
  end

  initial begin
    rst = 1'b1; req = 8'hFF; mode = 1'b0; gnt_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_valid", gnt_valid, 0);
    chk("init_idx", gnt_idx, 0);
    chk("init_onehot", gnt_onehot, 0);
    chk("init_cnt", gnt_cnt, 0);
    #2;
    req = 8'h00;
    rst = 1'b0;

    // Fixed priority with sticky grant
    step(8'h26, 1'b0, 1'b0);
    #3;
    chk("fix_idx", gnt_idx, 5);
    chk("fix_onehot", gnt_onehot, 8'h20);
    for (int i = 0; i < 3; i++) step(8'h01, 1'b0, 1'b0);
    #3;
    chk("sticky_idx", gnt_idx, 5);
    step(8'h01, 1'b0, 1'b1);
    #3;
    chk("accept_cnt", gnt_cnt, 1);
    chk("accept_idx", gnt_idx, 0);
    step(8'h00, 1'b0, 1'b1);
    #3;
    chk("to_idle_valid", gnt_valid, 0);
    chk("to_idle_idx_held", gnt_idx, 0);
    step(8'h00, 1'b0, 1'b1);   // ack in IDLE is ignored
    #3;
    chk("idle_ack_cnt", gnt_cnt, 2);

    // Back-to-back fixed priority
    do_reset(8'h00);
    step(8'h26, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(8'h26, 1'b0, 1'b1);
    #3;
    chk("b2b_cnt", gnt_cnt, 10);
    chk("b2b_idx", gnt_idx, 5);

    // mode=1 with all requests: rotation or constant 7
    do_reset(8'h00);
    step(8'hFF, 1'b1, 1'b0);
    #3;
    chk("rr_first", gnt_idx, 7);
    for (int k = 0; k < 8; k++) begin
      step(8'hFF, 1'b1, 1'b1);
      #3;
      chk("rr_seq", gnt_idx, RR ? (6 - k + 8) % 8 : 7);
    end

    // Counter wrap after 256 accepts
    do_reset(8'h00);
    step(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step(8'hFF, 1'b0, 1'b1);
    #3;
    chk("cnt_255", gnt_cnt, 255);
    step(8'hFF, 1'b0, 1'b1);
    #3;
    chk("cnt_wrap", gnt_cnt, 0);

    // Async reset while granting, then pointer-reset check with 8'h81
    chk("pre_rst_valid", gnt_valid, 1);
    do_reset(8'h81);
    step(8'h81, 1'b1, 1'b0);
    #3;
    chk("post_rst_idx", gnt_idx, 7);
    step(8'h81, 1'b1, 1'b1);
    #3;
    chk("rr_81_next", gnt_idx, RR ? 0 : 7);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) do_reset(r);
      step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
